hazard_bypass_ctrl: RTL and testbench

Pipeline hazard and bypass controller for the 5-stage MIPS core, located in the ID stage next to the per-operand register bypass muxes.
- Generates the bypass-select codes for the rs and rt operand muxes.
- Detects load-use hazards.
- Sequences multi-cycle stalls for memory wait and mul/div.
- Issues pipeline flushes on exceptions.
- Keeps a saturating stall-cycle performance counter.

---
 rtl/hazard_bypass_ctrl.sv | 163 ++++++++++++++++
 tb/tb_hazard_bypass_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_bypass_ctrl.sv
// rtl/hazard_bypass_ctrl.sv - ID-stage bypass select, load-use detect and stall/flush sequencing
module hazard_bypass_ctrl #(
  parameter int MULDIV_CYCLES = 32,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs_addr,
  input  logic             id_rs_used,
  input  logic [4:0]       id_rt_addr,
  input  logic             id_rt_used,
  input  logic [4:0]       ex_dest_addr,
  input  logic [1:0]       ex_access_type,
  input  logic [4:0]       mm_dest_addr,
  input  logic [1:0]       mm_access_type,
  input  logic [4:0]       wb_dest_addr,
  input  logic             wb_we,
  input  logic             mem_busy,
  input  logic             muldiv_start,
  input  logic             exc_flush,
  output logic [1:0]       rs_sel,
  output logic [1:0]       rt_sel,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             stall_mm,
  output logic             bubble_ex,
  output logic             flush,
  output logic             busy,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [1:0] MEM_ACCESS_TYPE_R2R = 2'b01;
  localparam logic [1:0] MEM_ACCESS_TYPE_M2R = 2'b10;

  localparam int            MD_W    = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;
  localparam logic [MD_W-1:0] MD_LOAD = MD_W'(MULDIV_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_MEM_WAIT,
    ST_MULDIV,
    ST_FLUSH
  } state_t;

  state_t          state, state_nxt;
  logic [MD_W-1:0] md_cnt, md_cnt_nxt;
  logic            load_use;
  logic            sif_c, sid_c, sex_c, smm_c, bub_c, flush_c;

  // A result is forwardable from EX only for register ops (loads are not ready
  // yet); from MM both register ops and loads are ready.
  function automatic logic [1:0] bypass_sel(
    input logic [4:0] addr,
    input logic [4:0] ex_d, input logic [1:0] ex_t,
    input logic [4:0] mm_d, input logic [1:0] mm_t,
    input logic [4:0] wb_d, input logic       wb_w
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (addr == 5'd0)
      sel = 2'b00;
    else if (addr == ex_d && ex_t == MEM_ACCESS_TYPE_R2R)
      sel = 2'b01;
    else if (addr == mm_d && (mm_t == MEM_ACCESS_TYPE_R2R || mm_t == MEM_ACCESS_TYPE_M2R))
      sel = 2'b10;
    else if (addr == wb_d && wb_w)
      sel = 2'b11;
    return sel;
  endfunction

  assign rs_sel = bypass_sel(id_rs_addr, ex_dest_addr, ex_access_type,
                             mm_dest_addr, mm_access_type, wb_dest_addr, wb_we);
  assign rt_sel = bypass_sel(id_rt_addr, ex_dest_addr, ex_access_type,
                             mm_dest_addr, mm_access_type, wb_dest_addr, wb_we);

  assign load_use = (ex_access_type == MEM_ACCESS_TYPE_M2R) && (ex_dest_addr != 5'd0) &&
                    ((id_rs_used && id_rs_addr == ex_dest_addr) ||
                     (id_rt_used && id_rt_addr == ex_dest_addr));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_RUN;
      md_cnt <= '0;
    end else begin
      state  <= state_nxt;
      md_cnt <= md_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    md_cnt_nxt = md_cnt;
    sif_c      = 1'b0;
    sid_c      = 1'b0;
    sex_c      = 1'b0;
    smm_c      = 1'b0;
    bub_c      = 1'b0;
    flush_c    = 1'b0;
    case (state)
      ST_RUN: begin
        if (exc_flush) begin
          state_nxt = ST_FLUSH;
          flush_c   = 1'b1;
        end else if (mem_busy) begin
          state_nxt = ST_MEM_WAIT;
          sif_c = 1'b1; sid_c = 1'b1; sex_c = 1'b1; smm_c = 1'b1;
        end else if (muldiv_start) begin
          state_nxt  = ST_MULDIV;
          md_cnt_nxt = MD_LOAD;
        end else if (load_use) begin
          sif_c = 1'b1; sid_c = 1'b1; bub_c = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (exc_flush) begin
          state_nxt = ST_FLUSH;
          flush_c   = 1'b1;
        end else if (mem_busy) begin
          sif_c = 1'b1; sid_c = 1'b1; sex_c = 1'b1; smm_c = 1'b1;
        end else begin
          state_nxt = ST_RUN;
        end
      end
      ST_MULDIV: begin
        if (exc_flush) begin
          state_nxt  = ST_FLUSH;
          md_cnt_nxt = '0;
          flush_c    = 1'b1;
        end else begin
          sif_c = 1'b1; sid_c = 1'b1; sex_c = 1'b1;
          smm_c = mem_busy;
          if (md_cnt == '0)
            state_nxt = ST_RUN;
          else
            md_cnt_nxt = md_cnt - 1'b1;
        end
      end
      ST_FLUSH: begin
        flush_c   = 1'b1;
        state_nxt = ST_RUN;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  // Reset is asynchronous, so the control outputs are forced low while it is held.
  assign stall_if  = sif_c   & ~rst;
  assign stall_id  = sid_c   & ~rst;
  assign stall_ex  = sex_c   & ~rst;
  assign stall_mm  = smm_c   & ~rst;
  assign bubble_ex = bub_c   & ~rst;
  assign flush     = flush_c & ~rst;
  assign busy      = (state != ST_RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_count <= '0;
    else if (stall_if && stall_count != {CNT_W{1'b1}})
      stall_count <= stall_count + 1'b1;
  end

endmodule

// File: tb/tb_hazard_bypass_ctrl.sv
// tb/tb_hazard_bypass_ctrl.sv - table, directed and random checks of hazard_bypass_ctrl
module tb_hazard_bypass_ctrl;

  localparam int MD = 4;
  localparam int CW = 5;
  localparam logic [1:0] T_NONE = 2'b00;
  localparam logic [1:0] T_R2R  = 2'b01;
  localparam logic [1:0] T_M2R  = 2'b10;
  localparam logic [1:0] T_R2M  = 2'b11;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs_addr, id_rt_addr, ex_dest_addr, mm_dest_addr, wb_dest_addr;
  logic id_rs_used, id_rt_used, wb_we, mem_busy, muldiv_start, exc_flush;
  logic [1:0] ex_access_type, mm_access_type;
  logic [1:0] rs_sel, rt_sel;
  logic stall_if, stall_id, stall_ex, stall_mm, bubble_ex, flush, busy;
  logic [CW-1:0] stall_count;

  always #5 clk = ~clk;

  hazard_bypass_ctrl #(.MULDIV_CYCLES(MD), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs_addr(id_rs_addr), .id_rs_used(id_rs_used),
    .id_rt_addr(id_rt_addr), .id_rt_used(id_rt_used),
    .ex_dest_addr(ex_dest_addr), .ex_access_type(ex_access_type),
    .mm_dest_addr(mm_dest_addr), .mm_access_type(mm_access_type),
    .wb_dest_addr(wb_dest_addr), .wb_we(wb_we),
    .mem_busy(mem_busy), .muldiv_start(muldiv_start), .exc_flush(exc_flush),
    .rs_sel(rs_sel), .rt_sel(rt_sel),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mm(stall_mm),
    .bubble_ex(bubble_ex), .flush(flush), .busy(busy), .stall_count(stall_count)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: pipeline condition flags plus remaining mul/div cycles.
  bit m_memwait, m_flushst;
  int m_md_left, m_cnt;
  logic [1:0] e_rs, e_rt;
  logic e_sif, e_sid, e_sex, e_smm, e_bub, e_fl, e_busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_sel(input logic [4:0] a);
    logic [4:0] d[3];
    bit ok[3];
    d[0] = ex_dest_addr; ok[0] = (ex_access_type == T_R2R);
    d[1] = mm_dest_addr; ok[1] = (mm_access_type == T_R2R) || (mm_access_type == T_M2R);
    d[2] = wb_dest_addr; ok[2] = wb_we;
    if (a == 5'd0) return 2'b00;
    for (int k = 0; k < 3; k++)
      if (ok[k] && d[k] == a) return 2'(k + 1);
    return 2'b00;
  endfunction

  task automatic model_reset();
    m_memwait = 0; m_flushst = 0; m_md_left = 0; m_cnt = 0;
  endtask

  task automatic compute_expected();
    bit lu;
    e_rs = ref_sel(id_rs_addr);
    e_rt = ref_sel(id_rt_addr);
    {e_sif, e_sid, e_sex, e_smm, e_bub, e_fl} = '0;
    e_busy = m_memwait || m_flushst || (m_md_left > 0);
    lu = (ex_access_type == T_M2R) && (ex_dest_addr != 0) &&
         ((id_rs_used && id_rs_addr == ex_dest_addr) || (id_rt_used && id_rt_addr == ex_dest_addr));
    if (rst) begin
      // everything held low
    end else if (exc_flush || m_flushst) begin
      e_fl = 1;
    end else if (m_md_left > 0) begin
      {e_sif, e_sid, e_sex} = 3'b111;
      e_smm = mem_busy;
    end else if (m_memwait || mem_busy) begin
      {e_sif, e_sid, e_sex, e_smm} = {4{mem_busy}};
    end else if (!muldiv_start && lu) begin
      {e_sif, e_sid, e_bub} = 3'b111;
    end
  endtask

  task automatic model_advance();
    if (rst) begin
      model_reset();
      return;
    end
    if (e_sif && m_cnt < (1 << CW) - 1) m_cnt++;
    if (m_flushst) begin
      m_flushst = 0;
    end else if (exc_flush) begin
      m_flushst = 1; m_memwait = 0; m_md_left = 0;
    end else if (m_memwait) begin
      m_memwait = mem_busy;
    end else if (m_md_left > 0) begin
      m_md_left--;
    end else if (mem_busy) begin
      m_memwait = 1;
    end else if (muldiv_start) begin
      m_md_left = MD;
    end
  endtask

  task automatic settle();
    @(negedge clk);
    compute_expected();
    chk("rs_sel", rs_sel, e_rs);
    chk("rt_sel", rt_sel, e_rt);
    chk("stall_if", stall_if, e_sif);
    chk("stall_id", stall_id, e_sid);
    chk("stall_ex", stall_ex, e_sex);
    chk("stall_mm", stall_mm, e_smm);
    chk("bubble_ex", bubble_ex, e_bub);
    chk("flush", flush, e_fl);
    chk("busy", busy, e_busy);
    chk("stall_count", stall_count, m_cnt);
  endtask

  task automatic advance();
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic idle_inputs();
    id_rs_addr = 0; id_rs_used = 0; id_rt_addr = 0; id_rt_used = 0;
    ex_dest_addr = 0; ex_access_type = T_NONE;
    mm_dest_addr = 0; mm_access_type = T_NONE;
    wb_dest_addr = 0; wb_we = 0;
    mem_busy = 0; muldiv_start = 0; exc_flush = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    model_reset();
    settle();
    advance();
    rst = 0;
  endtask

  typedef struct {
    logic [4:0] rs; logic ru; logic [4:0] rt; logic tu;
    logic [4:0] exd; logic [1:0] ext;
    logic [4:0] mmd; logic [1:0] mmt;
    logic [4:0] wbd; logic we;
    logic [1:0] x_rs; logic [1:0] x_rt; logic x_lu;
  } vec_t;

  vec_t tbl[13];

  initial begin
    tbl[0]  = '{5'd5,  1'b1, 5'd0,  1'b0, 5'd5,  T_R2R,  5'd5,  T_R2R, 5'd0,  1'b0, 2'b01, 2'b00, 1'b0};
    tbl[1]  = '{5'd5,  1'b1, 5'd0,  1'b0, 5'd6,  T_R2R,  5'd5,  T_R2R, 5'd0,  1'b0, 2'b10, 2'b00, 1'b0};
    tbl[2]  = '{5'd0,  1'b1, 5'd0,  1'b1, 5'd0,  T_R2R,  5'd0,  T_R2R, 5'd0,  1'b1, 2'b00, 2'b00, 1'b0};
    tbl[3]  = '{5'd5,  1'b1, 5'd0,  1'b0, 5'd5,  T_M2R,  5'd7,  T_R2R, 5'd5,  1'b1, 2'b11, 2'b00, 1'b1};
    tbl[4]  = '{5'd3,  1'b1, 5'd8,  1'b1, 5'd8,  T_M2R,  5'd9,  T_R2R, 5'd9,  1'b1, 2'b00, 2'b00, 1'b1};
    tbl[5]  = '{5'd3,  1'b0, 5'd8,  1'b1, 5'd8,  T_R2M,  5'd8,  T_M2R, 5'd0,  1'b0, 2'b00, 2'b10, 1'b0};
    tbl[6]  = '{5'd3,  1'b0, 5'd8,  1'b1, 5'd1,  T_R2R,  5'd8,  T_R2M, 5'd8,  1'b1, 2'b00, 2'b11, 1'b0};
    tbl[7]  = '{5'd3,  1'b0, 5'd8,  1'b1, 5'd1,  T_R2R,  5'd8,  T_R2M, 5'd8,  1'b0, 2'b00, 2'b00, 1'b0};
    tbl[8]  = '{5'd2,  1'b1, 5'd8,  1'b0, 5'd8,  T_M2R,  5'd0,  T_NONE, 5'd0, 1'b0, 2'b00, 2'b00, 1'b0};
    tbl[9]  = '{5'd0,  1'b1, 5'd0,  1'b1, 5'd0,  T_M2R,  5'd0,  T_R2R, 5'd0,  1'b1, 2'b00, 2'b00, 1'b0};
    tbl[10] = '{5'd12, 1'b1, 5'd12, 1'b1, 5'd12, T_R2R,  5'd12, T_M2R, 5'd12, 1'b1, 2'b01, 2'b01, 1'b0};
    tbl[11] = '{5'd4,  1'b1, 5'd4,  1'b0, 5'd9,  T_NONE, 5'd4,  T_M2R, 5'd4,  1'b1, 2'b10, 2'b10, 1'b0};
    tbl[12] = '{5'd7,  1'b0, 5'd7,  1'b0, 5'd7,  T_M2R,  5'd7,  T_R2R, 5'd0,  1'b0, 2'b10, 2'b10, 1'b0};

    idle_inputs();
    rst = 1;
    model_reset();
    #2;
    chk("reset_busy", busy, 0);
    chk("reset_stall_count", stall_count, 0);
    chk("reset_stall_if", stall_if, 0);
    chk("reset_flush", flush, 0);
    do_reset();

    // Table: combinational bypass / load-use in RUN.
    for (int i = 0; i < 13; i++) begin
      id_rs_addr = tbl[i].rs; id_rs_used = tbl[i].ru;
      id_rt_addr = tbl[i].rt; id_rt_used = tbl[i].tu;
      ex_dest_addr = tbl[i].exd; ex_access_type = tbl[i].ext;
      mm_dest_addr = tbl[i].mmd; mm_access_type = tbl[i].mmt;
      wb_dest_addr = tbl[i].wbd; wb_we = tbl[i].we;
      settle();
      chk($sformatf("tbl%0d_rs_sel", i), rs_sel, tbl[i].x_rs);
      chk($sformatf("tbl%0d_rt_sel", i), rt_sel, tbl[i].x_rt);
      chk($sformatf("tbl%0d_stall_if", i), stall_if, tbl[i].x_lu);
      chk($sformatf("tbl%0d_bubble_ex", i), bubble_ex, tbl[i].x_lu);
      advance();
    end

    // Load-use on rt, resolved from MM next cycle.
    do_reset();
    id_rt_addr = 8; id_rt_used = 1; ex_dest_addr = 8; ex_access_type = T_M2R;
    settle();
    chk("lu_stall_id", stall_id, 1);
    chk("lu_bubble", bubble_ex, 1);
    advance();
    ex_dest_addr = 0; ex_access_type = T_NONE; mm_dest_addr = 8; mm_access_type = T_M2R;
    settle();
    chk("lu_next_rt_sel", rt_sel, 2'b10);
    chk("lu_next_stall_if", stall_if, 0);
    chk("lu_count", stall_count, 1);
    advance();

    // Memory wait for three cycles.
    do_reset();
    mem_busy = 1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("mw_stall_mm", stall_mm, 1);
      chk("mw_busy", busy, (i != 0));
      advance();
    end
    mem_busy = 0;
    settle();
    chk("mw_drop_stall_if", stall_if, 0);
    chk("mw_drop_busy", busy, 1);
    advance();
    settle();
    chk("mw_run_busy", busy, 0);
    chk("mw_count", stall_count, 3);
    advance();

    // Mul/div hold.
    do_reset();
    muldiv_start = 1;
    settle();
    chk("md_start_stall_ex", stall_ex, 0);
    advance();
    muldiv_start = 0;
    begin
      int n;
      n = 0;
      for (int i = 0; i < 7; i++) begin
        settle();
        if (stall_ex) n++;
        advance();
      end
      chk("md_ex_cycles", n, MD);
    end
    chk("md_count", stall_count, MD);

    // Exception in the second mul/div cycle.
    do_reset();
    muldiv_start = 1;
    settle();
    advance();
    muldiv_start = 0;
    settle();
    advance();
    exc_flush = 1;
    settle();
    chk("xf_flush0", flush, 1);
    chk("xf_stall_ex0", stall_ex, 0);
    advance();
    exc_flush = 0;
    settle();
    chk("xf_flush1", flush, 1);
    chk("xf_busy1", busy, 1);
    advance();
    settle();
    chk("xf_flush2", flush, 0);
    chk("xf_busy2", busy, 0);
    chk("xf_stall_ex2", stall_ex, 0);
    advance();

    // Asynchronous reset in the middle of a memory wait.
    do_reset();
    mem_busy = 1;
    settle(); advance();
    settle(); advance();
    #2;
    rst = 1;
    #1;
    chk("ar_stall_mm", stall_mm, 0);
    chk("ar_stall_if", stall_if, 0);
    chk("ar_busy", busy, 0);
    chk("ar_count", stall_count, 0);
    model_reset();
    mem_busy = 0;
    settle();
    advance();
    rst = 0;

    // Random traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      id_rs_addr = 5'($urandom_range(0, 3)); id_rs_used = 1'($urandom_range(0, 1));
      id_rt_addr = 5'($urandom_range(0, 3)); id_rt_used = 1'($urandom_range(0, 1));
      ex_dest_addr = 5'($urandom_range(0, 3)); ex_access_type = 2'($urandom_range(0, 3));
      mm_dest_addr = 5'($urandom_range(0, 3)); mm_access_type = 2'($urandom_range(0, 3));
      wb_dest_addr = 5'($urandom_range(0, 3)); wb_we = 1'($urandom_range(0, 1));
      mem_busy = ($urandom_range(0, 3) == 0);
      muldiv_start = ($urandom_range(0, 7) == 0);
      exc_flush = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 299) == 0) begin
        rst = 1;
        model_reset();
      end else begin
        rst = 0;
      end
      settle();
      advance();
    end
    rst = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
